// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file writeback arbiter with a pending-write scoreboard.
// Two writeback sources share one RF write port, ALU (0) and memory (1).
// A round-robin grant picks one source per cycle, and the accepted write is
// registered onto the RF port one cycle later.
// A busy bit per register tracks writes that have been issued but not yet
// committed. It drives RAW hazard detection for the instruction in decode
// and WAW detection for the instruction issuing.

module rf_wb_arbiter #(
    parameter int addr_width_p = 6
) (
    input  logic                      clk,
    input  logic                      n_reset,

    // issue side: destination claim
    input  logic                      issue_v_i,
    input  logic [addr_width_p-1:0]   issue_addr_i,

    // decode side: source operands
    input  logic [addr_width_p-1:0]   rs_addr_i,
    input  logic [addr_width_p-1:0]   rd_addr_i,
    output logic                      hazard_o,
    output logic                      issue_busy_o,

    // writeback requesters: index 0 = ALU, index 1 = memory
    input  logic [1:0]                req_v_i,
    input  logic [2*addr_width_p-1:0] req_addr_i,
    input  logic [63:0]               req_data_i,
    output logic [1:0]                grant_o,

    // register-file write port (registered)
    output logic                      wen_o,
    output logic [addr_width_p-1:0]   write_addr_o,
    output logic [31:0]               write_data_o
);

    localparam int NREG = 1 << addr_width_p;

    // Index of the most recently granted requester. It resets to 1 so that
    // the ALU wins the first tie.
    logic                    r_last_grant;
    logic [NREG-1:0]         r_busy;

    logic [1:0]              w_grant;
    logic [addr_width_p-1:0] w_sel_addr;
    logic [31:0]             w_sel_data;
    logic [NREG-1:0]         w_set_mask;
    logic [NREG-1:0]         w_clr_mask;
    logic [NREG-1:0]         w_busy_next;

    // Round-robin grant: a lone request wins outright, and a tie goes to the
    // requester that was not granted last. Reset masks everything.
    always_comb begin
        w_grant = 2'b00;
        if (n_reset) begin
            case (req_v_i)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign grant_o = w_grant;

    // Select the granted requester's address and data for the write port.
    always_comb begin
        if (w_grant[1]) begin
            w_sel_addr = req_addr_i[2*addr_width_p-1:addr_width_p];
            w_sel_data = req_data_i[63:32];
        end else begin
            w_sel_addr = req_addr_i[addr_width_p-1:0];
            w_sel_data = req_data_i[31:0];
        end
    end

    // Remember who was granted. Idle cycles leave the history untouched.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_last_grant <= 1'b1;
        end else if (w_grant[0]) begin
            r_last_grant <= 1'b0;
        end else if (w_grant[1]) begin
            r_last_grant <= 1'b1;
        end
    end

    // Register the accepted write onto the RF port. Address and data hold
    // through idle cycles, and reset drops any write still in flight.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wen_o        <= 1'b0;
            write_addr_o <= '0;
            write_data_o <= '0;
        end else begin
            wen_o <= |w_grant;
            if (|w_grant) begin
                write_addr_o <= w_sel_addr;
                write_data_o <= w_sel_data;
            end
        end
    end

    // Scoreboard update. The commit cycle clears its bit, but it is OR-ed
    // with the issue set so that a same-address set wins the collision.
    // The clear comes from the registered port, which keeps the bit visible
    // to decode for the whole commit cycle.
    always_comb begin
        w_set_mask  = issue_v_i ? (NREG'(1) << issue_addr_i) : '0;
        w_clr_mask  = wen_o     ? (NREG'(1) << write_addr_o) : '0;
        w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // Busy-bit state: all registers become free on reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign hazard_o     = r_busy[rs_addr_i] | r_busy[rd_addr_i];
    assign issue_busy_o = r_busy[issue_addr_i];

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter addr_width_p, default 6, giving the register-address width (2**addr_width_p registers).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port n_reset, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port issue_v_i, input, 1 bit: an instruction issues this cycle and claims issue_addr_i as its destination.
REQ-005 The block SHALL have port issue_addr_i, input, addr_width_p bits: the destination register of the issuing instruction.
REQ-006 The block SHALL have ports rs_addr_i and rd_addr_i, input, addr_width_p bits each: the source registers of the instruction in decode.
REQ-007 The block SHALL have port hazard_o, output, 1 bit: rs_addr_i or rd_addr_i is pending a write.
REQ-008 The block SHALL have port issue_busy_o, output, 1 bit: issue_addr_i is already pending a write (WAW).
REQ-009 The block SHALL have port req_v_i, input, 2 bits: writeback request valid, where bit 0 is the ALU and bit 1 is memory.
REQ-010 The block SHALL have ports req_addr_i (2 x addr_width_p) and req_data_i (2 x 32), input: the per-requester write address and data.
REQ-011 The block SHALL have port grant_o, output, 2 bits: one-hot-or-zero; requester i is accepted this cycle.
REQ-012 The block SHALL have ports wen_o (1), write_addr_o (addr_width_p) and write_data_o (32), output and registered: they drive the register-file write port.

Function
REQ-013 grant_o SHALL be combinational from req_v_i and the last_grant register, with at most one bit set.
REQ-014 With a single valid request, the block SHALL grant that requester.
REQ-015 With both requests valid, the block SHALL grant the requester not recorded in last_grant (round-robin).
REQ-016 On any grant, last_grant SHALL update to the granted index at the next edge; with no grant, last_grant SHALL hold.
REQ-017 A requester SHALL hold req_v_i, req_addr_i and req_data_i stable until it is granted; a request that is not granted is not lost.
REQ-018 A grant in cycle N SHALL produce wen_o=1 in cycle N+1, with write_addr_o and write_data_o equal to the granted requester's values (latency 1).
REQ-019 wen_o SHALL be 0 in any cycle that does not follow a grant; write_addr_o and write_data_o SHALL hold their last values when wen_o is 0.
REQ-020 The block SHALL keep a scoreboard of 2**addr_width_p busy bits.
REQ-021 issue_v_i=1 SHALL set busy[issue_addr_i] at the next edge.
REQ-022 wen_o=1 SHALL clear busy[write_addr_o] at the edge that ends the commit cycle.
REQ-023 When a set and a clear target the same address at the same edge, the set SHALL win and the bit SHALL remain 1.
REQ-024 hazard_o SHALL equal busy[rs_addr_i] OR busy[rd_addr_i], combinationally.
REQ-025 hazard_o SHALL remain 1 throughout the commit cycle (wen_o=1) for the written address.
REQ-026 issue_busy_o SHALL equal busy[issue_addr_i], combinationally.
REQ-027 Upstream SHALL NOT assert issue_v_i while issue_busy_o=1; the block SHALL leave the bit set if it does.
REQ-028 Address 0 SHALL receive no special treatment: it is tracked and written like every other register.
REQ-029 A writeback to a register whose busy bit is 0 SHALL still be written and SHALL leave the bit at 0.

Reset
REQ-030 While n_reset=0 at a rising edge, the block SHALL clear all busy bits and set wen_o=0, write_addr_o=0, write_data_o=0 and last_grant=1, so that requester 0 wins the first tie.
REQ-031 During reset, grant_o SHALL be 2'b00 regardless of req_v_i.
REQ-032 A reset asserted in the cycle after a grant SHALL drop that write: wen_o SHALL be 0 in the following cycle.
REQ-033 Requests held across reset SHALL be re-arbitrated from last_grant=1 after reset is released.

Verification
REQ-034 Scenario tie: reset, then req_v_i=2'b11 held with ALU address 5 and data 0xAAAA0001, memory address 9 and data 0xBBBB0002 -> grant_o=01 in cycle 1, 10 in cycle 2; wen_o with address 5/0xAAAA0001 in cycle 2, then address 9/0xBBBB0002 in cycle 3.
REQ-035 Scenario hazard: issue address 7 in cycle 0, rs_addr_i=7 -> hazard_o=1 from cycle 1; memory writeback to address 7 granted in cycle 4 -> wen_o=1 in cycle 5, hazard_o=1 in cycle 5 and 0 in cycle 6.
REQ-036 Scenario set/clear collision: wen_o=1 to address 3 in the same cycle as issue_v_i to address 3 -> busy[3] stays 1 and issue_busy_o=1 the next cycle.
REQ-037 Scenario single requester: req_v_i=2'b10 for 3 consecutive requests -> grant_o=10 each cycle, three consecutive wen_o pulses, last_grant=1.
REQ-038 Scenario reset mid-flight: grant in cycle N, n_reset=0 at the edge ending cycle N -> wen_o=0 in cycle N+1, all busy bits 0, grant_o=00 while reset is held.
REQ-039 Scenario WAW check: busy[12]=1 with issue_addr_i=12 -> issue_busy_o=1; with issue_addr_i=13 -> issue_busy_o=0.
